// File: rtl/irq_sequencer.sv
// rtl/irq_sequencer.sv - interrupt sequencer: sync, latch, prioritise and take IRQs at a safe ID boundary
// Optional IRQ_MASK_EN adds a writable mask register; without it the mask is all ones.
module irq_sequencer #(
  parameter int N_SRC       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CAUSE_W     = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_SRC-1:0]   irq_src,
  input  logic [31:0]        id_pc,
  input  logic               id_valid,
  input  logic               id_in_delay_slot,
  input  logic               pipe_stall,
  input  logic               eret,
  input  logic               mask_we,
  input  logic [N_SRC-1:0]   mask_wdata,
  output logic               irq_take,
  output logic               flush_if_id,
  output logic               epc_we,
  output logic [31:0]        epc,
  output logic [CAUSE_W-1:0] cause,
  output logic               kernel_mode,
  output logic [N_SRC-1:0]   pending
);

  typedef enum logic [1:0] {IDLE, WAIT, TAKE, KERNEL} state_t;

  state_t             state, next_state;
  logic [N_SRC-1:0]   sync_q [SYNC_STAGES];
  logic [N_SRC-1:0]   edge_q;
  logic [N_SRC-1:0]   rise;
  logic [N_SRC-1:0]   mask;
  logic [N_SRC-1:0]   eligible;
  logic [N_SRC-1:0]   clr;
  logic [CAUSE_W-1:0] sel;

`ifdef IRQ_MASK_EN
  logic [N_SRC-1:0] mask_q;

  always_ff @(posedge clk) begin
    if (reset)        mask_q <= '1;
    else if (mask_we) mask_q <= mask_wdata;
  end

  assign mask = mask_q;
`else
  logic unused_mask;

  assign mask        = '1;
  assign unused_mask = ^{mask_we, mask_wdata};
`endif

  assign rise     = sync_q[SYNC_STAGES-1] & ~edge_q;
  assign eligible = pending & mask;
  assign clr      = (state == TAKE) ? (N_SRC'(1) << cause) : '0;

  // Downward scan so the lowest set index is the last (winning) assignment.
  always_comb begin
    sel = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) sel = CAUSE_W'(i);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (|eligible && !kernel_mode) next_state = WAIT;
      WAIT: begin
        if (!(|eligible))                                      next_state = IDLE;
        else if (id_valid && !id_in_delay_slot && !pipe_stall) next_state = TAKE;
      end
      TAKE:   next_state = KERNEL;
      KERNEL: if (eret) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      edge_q      <= '0;
      pending     <= '0;
      state       <= IDLE;
      irq_take    <= 1'b0;
      flush_if_id <= 1'b0;
      epc_we      <= 1'b0;
      epc         <= '0;
      cause       <= '0;
      kernel_mode <= 1'b0;
    end else begin
      sync_q[0] <= irq_src;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      edge_q      <= sync_q[SYNC_STAGES-1];
      pending     <= (pending & ~clr) | rise;
      state       <= next_state;
      irq_take    <= (next_state == TAKE);
      flush_if_id <= (next_state == TAKE);
      epc_we      <= (next_state == TAKE);
      kernel_mode <= (next_state == KERNEL);
      if (state == WAIT && next_state == TAKE) begin
        cause <= sel;
        epc   <= id_pc;
      end
    end
  end

endmodule

// File: tb/tb_irq_sequencer.sv
// tb/tb_irq_sequencer.sv - scoreboard bench for irq_sequencer with directed vectors
module tb_irq_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  irq_src = '0;
  logic [31:0] id_pc = '0;
  logic        id_valid = 1'b1;
  logic        id_in_delay_slot = 1'b0;
  logic        pipe_stall = 1'b0;
  logic        eret = 1'b0;
  logic        mask_we = 1'b0;
  logic [3:0]  mask_wdata = 4'hF;
  logic        irq_take, flush_if_id, epc_we, kernel_mode;
  logic [31:0] epc;
  logic [1:0]  cause;
  logic [3:0]  pending;

  irq_sequencer dut (
    .clk(clk), .reset(reset), .irq_src(irq_src), .id_pc(id_pc), .id_valid(id_valid),
    .id_in_delay_slot(id_in_delay_slot), .pipe_stall(pipe_stall), .eret(eret),
    .mask_we(mask_we), .mask_wdata(mask_wdata), .irq_take(irq_take),
    .flush_if_id(flush_if_id), .epc_we(epc_we), .epc(epc), .cause(cause),
    .kernel_mode(kernel_mode), .pending(pending)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          at;
    logic [1:0]  cause;
    logic [31:0] epc;
  } take_t;
  take_t sb[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every cycle the take strobes must match whether a take is scheduled now.
  always @(negedge clk) begin
    logic  want;
    take_t r;
    while (sb.size() > 0 && sb[0].at < cyc) begin
      checks++;
      errors++;
      $display("FAIL missed_take actual=none required=cycle_%0d", sb[0].at);
      sb.delete(0);
    end
    want = (sb.size() > 0 && sb[0].at == cyc);
    check("irq_take", 32'(irq_take), 32'(want));
    check("flush_if_id", 32'(flush_if_id), 32'(want));
    check("epc_we", 32'(epc_we), 32'(want));
    if (want) begin
      r = sb.pop_front();
      check("take_cause", 32'(cause), 32'(r.cause));
      check("take_epc", epc, r.epc);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, d;

    tick(2);
    check("rst_irq_take", 32'(irq_take), 0);
    check("rst_flush", 32'(flush_if_id), 0);
    check("rst_epc_we", 32'(epc_we), 0);
    check("rst_epc", epc, 0);
    check("rst_cause", 32'(cause), 0);
    check("rst_kernel", 32'(kernel_mode), 0);
    check("rst_pending", 32'(pending), 0);
    reset = 1'b0;
    tick(2);

    // single request on source 2
    c = cyc;
    irq_src = 4'b0100;
    id_pc = 32'h0040_0020;
    sb.push_back('{c + 5, 2'd2, 32'h0040_0020});
    tick(6);
    check("t1_kernel", 32'(kernel_mode), 1);
    check("t1_pending", 32'(pending), 0);
    irq_src = '0;
    eret = 1'b1;
    tick(1);
    eret = 1'b0;
    check("t1_kernel_cleared", 32'(kernel_mode), 0);
    tick(4);

    // delay-slot then stall deferral, with a stray eret in WAIT
    c = cyc;
    irq_src = 4'b1000;
    sb.push_back('{c + 10, 2'd3, 32'h0000_1024});
    for (int k = 0; k < 10; k++) begin
      id_pc = 32'h1000 + 32'(4 * k);
      id_in_delay_slot = (k <= 6);
      pipe_stall = (k == 7 || k == 8);
      eret = (k == 5);
      tick(1);
    end
    id_in_delay_slot = 1'b0;
    pipe_stall = 1'b0;
    eret = 1'b0;
    tick(1);
    check("t2_kernel", 32'(kernel_mode), 1);
    irq_src = '0;
    eret = 1'b1;
    tick(1);
    eret = 1'b0;
    tick(4);

    // simultaneous sources 1 and 3
    c = cyc;
    irq_src = 4'b1010;
    id_pc = 32'h0000_2000;
    sb.push_back('{c + 5, 2'd1, 32'h0000_2000});
    tick(6);
    check("t3_pending_queued", 32'(pending), 32'b1000);
    check("t3_kernel", 32'(kernel_mode), 1);
    d = cyc;
    eret = 1'b1;
    id_pc = 32'h0000_2040;
    sb.push_back('{d + 3, 2'd3, 32'h0000_2040});
    tick(1);
    eret = 1'b0;
    tick(3);
    check("t3_pending_drained", 32'(pending), 0);
    check("t3_kernel2", 32'(kernel_mode), 1);
    eret = 1'b1;
    irq_src = '0;
    tick(1);
    eret = 1'b0;
    tick(4);

    // new edge while in kernel is held until eret
    c = cyc;
    irq_src = 4'b0100;
    id_pc = 32'h0000_3000;
    sb.push_back('{c + 5, 2'd2, 32'h0000_3000});
    tick(6);
    irq_src = 4'b0101;
    tick(8);
    check("t4_pending_blocked", 32'(pending), 32'b0001);
    check("t4_kernel", 32'(kernel_mode), 1);
    d = cyc;
    eret = 1'b1;
    id_pc = 32'h0000_3100;
    sb.push_back('{d + 3, 2'd0, 32'h0000_3100});
    tick(1);
    eret = 1'b0;
    tick(3);
    check("t4_kernel2", 32'(kernel_mode), 1);
    eret = 1'b1;
    tick(1);
    eret = 1'b0;

    // level held high on source 0 produces no further take
    tick(20);
    check("t5_level_pending", 32'(pending), 0);
    check("t5_level_kernel", 32'(kernel_mode), 0);
    irq_src = '0;
    tick(4);

    // reset while in WAIT abandons the take
    c = cyc;
    irq_src = 4'b0010;
    tick(4);
    check("t5_wait_pending", 32'(pending), 32'b0010);
    reset = 1'b1;
    irq_src = '0;
    tick(1);
    check("t5_rst_pending", 32'(pending), 0);
    check("t5_rst_kernel", 32'(kernel_mode), 0);
    check("t5_rst_epc", epc, 0);
    check("t5_rst_cause", 32'(cause), 0);
    reset = 1'b0;
    tick(10);
    check("t5_post_rst_pending", 32'(pending), 0);

`ifdef IRQ_MASK_EN
    // mask away a waiting request, then unmask it
    id_valid = 1'b0;
    c = cyc;
    irq_src = 4'b0001;
    tick(4);
    mask_we = 1'b1;
    mask_wdata = 4'b1110;
    tick(1);
    mask_we = 1'b0;
    tick(3);
    check("t6_masked_pending", 32'(pending), 32'b0001);
    id_valid = 1'b1;
    tick(3);
    check("t6_masked_kernel", 32'(kernel_mode), 0);
    d = cyc;
    mask_we = 1'b1;
    mask_wdata = 4'b1111;
    id_pc = 32'h0000_4000;
    sb.push_back('{d + 3, 2'd0, 32'h0000_4000});
    tick(1);
    mask_we = 1'b0;
    tick(3);
    check("t6_kernel", 32'(kernel_mode), 1);
    eret = 1'b1;
    irq_src = '0;
    tick(1);
    eret = 1'b0;
`endif

    tick(5);
    check("sb_empty", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_sequencer.md
Name: irq_sequencer

Overview:
- Interrupt sequencer for the 5-stage MIPS pipeline.
- Synchronises and latches external interrupt sources, and arbitrates them by fixed priority.
- Picks a safe ID-stage instruction boundary to take the interrupt, then drives the Control unit's IRQ input, the EPC write and the IF/ID flush.
- Tracks kernel mode until the handler returns with an eret indication.

Parameters:
- N_SRC, 4, number of interrupt source lines; index 0 is highest priority.
- SYNC_STAGES, 2, synchroniser flop depth per source (minimum 2).
- CAUSE_W, 2, width of the cause code; must satisfy 2**CAUSE_W >= N_SRC.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- irq_src  in  N_SRC  asynchronous level interrupt requests.
- id_pc  in  32  PC of the instruction currently in ID.
- id_valid  in  1  ID holds a real, non-bubble instruction.
- id_in_delay_slot  in  1  ID instruction is a branch/jump delay slot.
- pipe_stall  in  1  hazard unit is stalling IF/ID this cycle.
- eret  in  1  handler return retiring this cycle.
- mask_we  in  1  mask register write strobe (IRQ_MASK_EN only).
- mask_wdata  in  N_SRC  new mask value (IRQ_MASK_EN only).
- irq_take  out  1  drives the Control IRQ input (selects PCSrc 3'b011).
- flush_if_id  out  1  squashes the IF/ID register.
- epc_we  out  1  EPC register write enable.
- epc  out  32  value to write into EPC.
- cause  out  CAUSE_W  index of the source being serviced.
- kernel_mode  out  1  handler is executing; further interrupts are blocked.
- pending  out  N_SRC  latched pending bits, for debug and status.

Behaviour:
- Reset: state IDLE. The following clear to 0: pending, sync flops, edge flops, irq_take, flush_if_id, epc_we, epc, cause, kernel_mode. Mask is set to all ones.
- Sync and edge detection:
  - Each irq_src bit passes through SYNC_STAGES flops.
  - pending[i] sets on a synchronised 0->1 transition.
  - A level held high sets pending only once.
- pending[i] clears in the TAKE cycle for i == cause. If a new edge on the same bit arrives in that same cycle, the set wins.
- eligible = pending & mask.
- IDLE: if eligible != 0 and kernel_mode == 0, go to WAIT.
- WAIT:
  - If eligible == 0 (e.g. masked away), return to IDLE.
  - Else, if id_valid && !id_in_delay_slot && !pipe_stall, go to TAKE. Register cause = lowest-index set bit of eligible, and register epc = id_pc.
  - Else stay in WAIT.
- TAKE (exactly 1 cycle):
  - irq_take = 1, flush_if_id = 1, epc_we = 1.
  - cause and epc are stable for this cycle.
  - Next state is KERNEL, with kernel_mode = 1.
- KERNEL:
  - irq_take, flush_if_id and epc_we are all 0.
  - New edges still latch into pending.
  - On eret go to IDLE and clear kernel_mode in the same edge.
  - Pending bits are re-evaluated from IDLE the following cycle, so there are no back-to-back takes without one IDLE cycle.
- Latency: with SYNC_STAGES=2 and no blocking, irq_src is first sampled high at edge 1 and irq_take is high in the cycle after edge 5. Sequence: pending at edge 3, WAIT at edge 4, TAKE at edge 5.
- Simultaneous sources: the lowest index is served. Others remain pending and are served after eret, one per handler.
- eret outside KERNEL is ignored.
- reset asserted in any state returns to the reset values on the next edge; any in-flight TAKE is abandoned.
- irq_take, flush_if_id and epc_we are registered outputs and are never asserted simultaneously with reset.

Optional Feature:
- Macro: IRQ_MASK_EN.
- Defined:
  - mask register of N_SRC bits, reset to all ones.
  - mask_we loads mask_wdata on the next edge.
  - A write that clears all eligible bits while in WAIT sends the FSM to IDLE on the following edge.
- Undefined:
  - mask is the constant all ones.
  - mask_we and mask_wdata are ignored.
  - No mask flops are synthesised.

Test Plan:
- Single request: irq_src[2] rises with id_valid=1, id_pc=0x00400020 -> irq_take, epc_we and flush_if_id all high for exactly 1 cycle, 5 edges later. epc=0x00400020, cause=2, kernel_mode=1 from the next cycle, pending=0.
- Delay-slot deferral: request arrives while id_in_delay_slot=1 for 3 cycles and pipe_stall=1 for 2 further cycles -> FSM stays in WAIT. Take occurs the first cycle both inputs are 0, and epc equals the id_pc of that cycle.
- Priority and queuing: irq_src[1] and irq_src[3] rise on the same edge -> first take has cause=1, pending=4'b1000. Pulse eret -> one IDLE cycle, then a second take with cause=3.
- Blocked in kernel: new irq_src[0] edge during KERNEL -> pending[0]=1 and no irq_take until eret. Once eret is asserted, irq_take follows exactly 3 cycles later (IDLE, WAIT, TAKE).
- Level hold and reset: irq_src[0] is held high for 20 cycles -> exactly one take. Assert reset during WAIT -> all outputs 0 and mask=all ones next cycle, with no take.
- With IRQ_MASK_EN: write mask=4'b1110 during WAIT for a source-0 request -> return to IDLE with pending[0] still 1. Write mask=4'b1111 -> take with cause=0.
